// File: rtl/sdram_pkg.sv
// SDRAM_PKG: shared types and timing tables for the SDRAM controller blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package SDRAM_PKG;
  localparam int N_BANKS  = 4;
  localparam int BA_W     = $clog2(N_BANKS);
  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 16;
  localparam int DQM_W    = DATA_W / 8;
  // A10 doubles as auto-precharge (READ/WRITE) and precharge-all (PRE).
  localparam int PALL_BIT = 10;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [3:0]        tag_t;

  typedef enum logic [1:0] {CAS_1, CAS_2, CAS_3} cas_t;
  localparam int N_CAS [4] = '{1, 2, 3, 3};

  typedef enum logic [1:0] {BURST_1, BURST_2, BURST_4, BURST_8} burst_t;
  localparam int N_BURSTS [4] = '{1, 2, 4, 8};

  typedef enum logic [2:0] {
    OP_NOP, OP_ACT, OP_READ, OP_WRITE, OP_PRE, OP_REF, OP_MRS
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [BA_W-1:0]   bank;
    logic [ADDR_W-1:0] addr;
    data_t             data;
  } cmd_t;
endpackage

// File: rtl/sdram_phy_cmd_if.sv
// Arbiter <-> PHY command/read-return bundle.
// Latency: n/a (wires only).
// Backpressure: CMD_ACK_OUT qualifies CMD_REQ_IN; the read return is never stalled.
// Ports: CMD_DATA_IN/CMD_REQ_IN (arbiter->PHY), CMD_ACK_OUT, READ_DATA_OUT,
//        READ_TAG_OUT (PHY->arbiter).
interface sdram_phy_cmd_if;
  SDRAM_PKG::cmd_t  CMD_DATA_IN;
  logic             CMD_REQ_IN;
  logic             CMD_ACK_OUT;
  SDRAM_PKG::data_t READ_DATA_OUT;
  SDRAM_PKG::tag_t  READ_TAG_OUT;

  modport master (output CMD_DATA_IN, CMD_REQ_IN,
                  input  CMD_ACK_OUT, READ_DATA_OUT, READ_TAG_OUT);
  modport slave  (input  CMD_DATA_IN, CMD_REQ_IN,
                  output CMD_ACK_OUT, READ_DATA_OUT, READ_TAG_OUT);
endinterface

// File: rtl/sdram_phy_cmd.sv
// sdram_phy_cmd: encodes arbiter commands onto registered SDRAM pins, drives write
//   beats on DQ and returns captured read beats with the read tag on beat 0.
// Latency: command/write beat 0 on pins 1 cycle after accept; read tag/beat 0 at
//   accept + 2 + tCAS + RD_EXTRA.
// Backpressure: none; CMD_ACK_OUT is 1 from the first clock after reset onward.
// Ports: CLK, RESET_IN (async, active high); arb = command/read-return bundle;
//   SD_* = SDRAM pins (split DQ: SD_DQ_OUT/SD_DQ_OE out, SD_DQ_IN in).
module sdram_phy_cmd #(
  parameter SDRAM_PKG::cas_t   CAS      = SDRAM_PKG::CAS_3,
  parameter SDRAM_PKG::burst_t BURST    = SDRAM_PKG::BURST_8,
  parameter int                RD_EXTRA = 0
) (
  input  logic                           CLK,
  input  logic                           RESET_IN,
  sdram_phy_cmd_if.slave                 arb,
  output logic                           SD_CKE,
  output logic                           SD_CS_N,
  output logic                           SD_RAS_N,
  output logic                           SD_CAS_N,
  output logic                           SD_WE_N,
  output logic [SDRAM_PKG::BA_W-1:0]     SD_BA,
  output logic [SDRAM_PKG::ADDR_W-1:0]   SD_A,
  output logic [SDRAM_PKG::DQM_W-1:0]    SD_DQM,
  output SDRAM_PKG::data_t               SD_DQ_OUT,
  output logic                           SD_DQ_OE,
  input  SDRAM_PKG::data_t               SD_DQ_IN
);
  import SDRAM_PKG::*;

  localparam int T_CAS   = N_CAS[CAS];
  localparam int T_BURST = N_BURSTS[BURST];
  // Tag travels alongside the command/CAS/capture/extra stages.
  localparam int TAG_LAT = T_CAS + 1 + RD_EXTRA;
  localparam int WR_W    = $clog2(T_BURST + 1);
  localparam int TAG_W   = $bits(tag_t);

  cmd_t              cmd;
  logic              ack_q;
  logic              accept;
  logic              is_rd;
  logic              is_wr;
  logic              cmd_vld;
  logic [2:0]        enc;      // {RAS_N, CAS_N, WE_N}
  logic [ADDR_W-1:0] a_nxt;
  logic [WR_W-1:0]   wr_left;  // write beats still to drive after the current one
  data_t             rd_pipe [RD_EXTRA+1];
  tag_t              tag_pipe [TAG_LAT];
  tag_t              tag_q;

  assign cmd     = arb.CMD_DATA_IN;
  assign accept  = arb.CMD_REQ_IN && ack_q;
  assign is_rd   = accept && (cmd.op == OP_READ);
  assign is_wr   = accept && (cmd.op == OP_WRITE);
  assign cmd_vld = accept && (cmd.op != OP_NOP);

  assign arb.CMD_ACK_OUT   = ack_q;
  assign arb.READ_DATA_OUT = rd_pipe[RD_EXTRA];
  assign arb.READ_TAG_OUT  = tag_q;

  always_comb begin
    enc   = 3'b111;
    a_nxt = cmd.addr;
    if (accept) begin
      case (cmd.op)
        OP_ACT:   enc = 3'b011;
        OP_READ:  begin enc = 3'b101; a_nxt[PALL_BIT] = 1'b0; end
        OP_WRITE: begin enc = 3'b100; a_nxt[PALL_BIT] = 1'b0; end
        OP_PRE:   enc = 3'b010;
        OP_REF:   enc = 3'b001;
        OP_MRS:   enc = 3'b000;
        default:  enc = 3'b111;
      endcase
    end
  end

  // Command pins. BA/A hold their last value across NOPs to avoid toggling.
  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      ack_q    <= 1'b0;
      SD_CKE   <= 1'b0;
      SD_CS_N  <= 1'b1;
      SD_RAS_N <= 1'b1;
      SD_CAS_N <= 1'b1;
      SD_WE_N  <= 1'b1;
      SD_BA    <= '0;
      SD_A     <= '0;
      SD_DQM   <= '1;
    end else begin
      ack_q    <= 1'b1;
      SD_CKE   <= 1'b1;
      SD_CS_N  <= 1'b0;
      SD_DQM   <= '0;
      {SD_RAS_N, SD_CAS_N, SD_WE_N} <= enc;
      if (cmd_vld) begin
        SD_BA <= cmd.bank;
        SD_A  <= a_nxt;
      end
    end
  end

  // Write burst: beat 0 goes out with the WRITE itself, later beats take the
  // data bus as presented on each following cycle. A new READ/WRITE cuts the
  // burst short; a WRITE simply starts a fresh one.
  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      wr_left   <= '0;
      SD_DQ_OE  <= 1'b0;
      SD_DQ_OUT <= '0;
    end else if (is_wr) begin
      wr_left   <= WR_W'(T_BURST - 1);
      SD_DQ_OE  <= 1'b1;
      SD_DQ_OUT <= cmd.data;
    end else if (is_rd) begin
      wr_left   <= '0;
      SD_DQ_OE  <= 1'b0;
    end else if (wr_left != '0) begin
      wr_left   <= wr_left - WR_W'(1);
      SD_DQ_OE  <= 1'b1;
      SD_DQ_OUT <= cmd.data;
    end else begin
      SD_DQ_OE  <= 1'b0;
    end
  end

  // Read capture runs free; only the tag marks where a burst starts.
  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      for (int i = 0; i <= RD_EXTRA; i++) rd_pipe[i] <= '0;
      for (int i = 0; i < TAG_LAT; i++) tag_pipe[i] <= '0;
      tag_q <= '0;
    end else begin
      rd_pipe[0] <= SD_DQ_IN;
      for (int i = 1; i <= RD_EXTRA; i++) rd_pipe[i] <= rd_pipe[i-1];
      tag_pipe[0] <= is_rd ? cmd.data[TAG_W-1:0] : '0;
      for (int i = 1; i < TAG_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      tag_q <= tag_pipe[TAG_LAT-1];
    end
  end

`ifndef SYNTHESIS
  // Bit i: a read beat is due on the DQ pins i cycles from now.
  localparam int EXP_W = T_CAS + T_BURST;
  localparam logic [EXP_W-1:0] RD_MASK = EXP_W'((1 << T_BURST) - 1) << T_CAS;
  logic [EXP_W-1:0] rd_exp;

  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) rd_exp <= '0;
    else          rd_exp <= (rd_exp >> 1) | (is_rd ? RD_MASK : '0);
  end

  always @(posedge CLK) begin
    if (!RESET_IN) assert (!(SD_DQ_OE && rd_exp[0]));
  end
`endif
endmodule
